// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package ifetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam int unsigned ROM_WORDS_DEFAULT = 64;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    typedef struct packed {
        word_t inst;
        addr_t pc;
    } fetch_entry_t;

    // A PC is unusable if misaligned or past the last ROM word; the PC never wraps.
    function automatic logic pc_bad(input addr_t pc, input int unsigned rom_words);
        return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= 32'(rom_words));
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry {inst, pc} buffer with push/pop/flush; head reads as zero when empty.
module ifetch_fifo
    import ifetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push_i && rst_n && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_ctrl.sv
// Sequential instruction fetch from a combinational ROM with redirect and range fault.
// Define IFETCH_PERF_EN to build the fetch/stall performance counters.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned ROM_WORDS = ROM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_a,
    input  logic [31:0] rom_rd,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    addr_t        pc_q, pc_d;
    logic         fifo_full, fifo_empty;
    logic         pop, fetch;
    fetch_entry_t head;

    // The fault is a decode of the held PC; it persists because a faulted PC never advances.
    assign fetch_fault = pc_bad(pc_q, ROM_WORDS);
    assign pop         = inst_valid && inst_ready;
    assign fetch       = !fetch_fault && !redirect_valid && (!fifo_full || pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)
            pc_d = redirect_pc;
        else if (fetch)
            pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    ifetch_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fetch),
        .push_data_i ('{inst: rom_rd, pc: pc_q}),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rom_a      = {2'b00, pc_q[31:2]};
    assign inst_valid = !fifo_empty;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (fetch)                    fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (inst_valid && !inst_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed scoreboard bench for ifetch_ctrl; counter checks follow IFETCH_PERF_EN.
module tb_ifetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_a;
    logic [31:0] rom_rd;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   stall_exp = 0;

    ifetch_ctrl #(.RESET_PC(32'h0000_0000), .ROM_WORDS(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_a          (rom_a),
        .rom_rd         (rom_rd),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        if (idx == 32'd0) return 32'h2008_0005;
        return (idx * 32'h9E37_79B9) ^ 32'h1357_0000;
    endfunction

    assign rom_rd = (rom_a < 32'd128) ? rom_word(rom_a) : 32'hDEAD_BEEF;

    function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef IFETCH_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", name, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc   = start + 32'(4 * i);
            e.inst = rom_word((start >> 2) + 32'(i));
            sb_q.push_back(e);
        end
    endtask

    // One clock: score the handshake about to happen, then advance to 1ns past the edge.
    task automatic cycle();
        if (rst_n && inst_valid && inst_ready) begin
            $display("xact pc=%h inst=%h", inst_pc, inst);
            check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_inst", inst, e.inst);
                check("sb_pc", inst_pc, e.pc);
            end
        end
        if (!rst_n)
            stall_exp = 0;
        else if (inst_valid && !inst_ready)
            stall_exp++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        cycle();
        cycle();

        // Reset state
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc", inst_pc, 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_rom_a", rom_a, 32'd0);
        check("rst_fcnt", perf_fetch_cnt, 32'd0);
        check("rst_scnt", perf_stall_cnt, 32'd0);

        // First fetch latency and full throughput
        rst_n = 1'b1;
        sb_q.delete();
        push_seq(32'd0, 8);
        check("c0_valid", 32'(inst_valid), 32'd0);
        cycle();
        check("c1_valid", 32'(inst_valid), 32'd1);
        check("c1_inst", inst, 32'h2008_0005);
        check("c1_pc", inst_pc, 32'd0);
        cycle();
        check("c2_pc", inst_pc, 32'd4);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("tput_valid", 32'(inst_valid), 32'd1);
        end
        check("tput_fcnt", perf_fetch_cnt, exp_perf(32'd6));
        check("tput_scnt", perf_stall_cnt, 32'd0);

        // Back-pressure: the buffer fills at two and the head holds
        rst_n      = 1'b0;
        inst_ready = 1'b0;
        cycle();
        sb_q.delete();
        check("rst2_valid", 32'(inst_valid), 32'd0);
        rst_n = 1'b1;
        push_seq(32'd0, 8);
        for (int i = 0; i < 6; i++) cycle();
        check("bp_valid", 32'(inst_valid), 32'd1);
        check("bp_pc", inst_pc, 32'd0);
        check("bp_inst", inst, 32'h2008_0005);
        check("bp_rom_a", rom_a, 32'd2);
        check("bp_scnt", perf_stall_cnt, exp_perf(32'd5));
        check("bp_scnt_model", perf_stall_cnt, exp_perf(32'(stall_exp)));
        check("bp_fcnt", perf_fetch_cnt, exp_perf(32'd2));
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Redirect while full, with a same-cycle handshake
        inst_ready = 1'b0;
        cycle();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cycle();
        redirect_valid = 1'b0;
        sb_q.delete();
        push_seq(32'h40, 6);
        check("rd_valid", 32'(inst_valid), 32'd0);
        check("rd_inst", inst, 32'd0);
        check("rd_pc0", inst_pc, 32'd0);
        check("rd_rom_a", rom_a, 32'd16);
        cycle();
        check("rd_tgt_valid", 32'(inst_valid), 32'd1);
        check("rd_tgt_pc", inst_pc, 32'h40);
        check("rd_tgt_inst", inst, rom_word(32'd16));
        for (int i = 0; i < 3; i++) cycle();

        // Run off the end of the ROM
        redirect_valid = 1'b1;
        redirect_pc    = 32'hF8;
        cycle();
        redirect_valid = 1'b0;
        sb_q.delete();
        push_seq(32'hF8, 2);
        check("end_valid0", 32'(inst_valid), 32'd0);
        check("end_fault0", 32'(fetch_fault), 32'd0);
        check("end_rom_a0", rom_a, 32'd62);
        cycle();
        check("end_f8", inst_pc, 32'hF8);
        check("end_fault1", 32'(fetch_fault), 32'd0);
        cycle();
        check("end_fc", inst_pc, 32'hFC);
        check("end_fault2", 32'(fetch_fault), 32'd1);
        check("end_rom_a2", rom_a, 32'd64);
        cycle();
        check("end_drained", 32'(inst_valid), 32'd0);
        check("end_inst0", inst, 32'd0);
        check("end_pc0", inst_pc, 32'd0);
        check("end_sb_empty", 32'(sb_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("end_idle_valid", 32'(inst_valid), 32'd0);
            check("end_idle_rom_a", rom_a, 32'd64);
            check("end_idle_fault", 32'(fetch_fault), 32'd1);
        end

        // Misaligned redirect, then recovery
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        cycle();
        redirect_valid = 1'b0;
        sb_q.delete();
        check("mis_fault", 32'(fetch_fault), 32'd1);
        check("mis_valid", 32'(inst_valid), 32'd0);
        check("mis_rom_a", rom_a, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("mis_idle_valid", 32'(inst_valid), 32'd0);
            check("mis_idle_fault", 32'(fetch_fault), 32'd1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        push_seq(32'd0, 6);
        check("rec_fault", 32'(fetch_fault), 32'd0);
        check("rec_valid", 32'(inst_valid), 32'd0);
        cycle();
        check("rec_tgt_valid", 32'(inst_valid), 32'd1);
        check("rec_tgt_pc", inst_pc, 32'd0);
        check("rec_tgt_inst", inst, 32'h2008_0005);

        // Reset mid-stream with a full buffer and a pending redirect
        inst_ready = 1'b0;
        cycle();
        cycle();
        rst_n          = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        cycle();
        redirect_valid = 1'b0;
        sb_q.delete();
        check("mrst_valid", 32'(inst_valid), 32'd0);
        check("mrst_fault", 32'(fetch_fault), 32'd0);
        check("mrst_inst", inst, 32'd0);
        check("mrst_pc", inst_pc, 32'd0);
        check("mrst_rom_a", rom_a, 32'd0);
        check("mrst_fcnt", perf_fetch_cnt, 32'd0);
        check("mrst_scnt", perf_stall_cnt, 32'd0);
        rst_n = 1'b1;
        push_seq(32'd0, 4);
        cycle();
        check("mrst_first_valid", 32'(inst_valid), 32'd1);
        check("mrst_first_pc", inst_pc, 32'd0);
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
